// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame erase / update / redraw sequencer for a 160x120 display.
//
// On every frame tick (while run is high) each sprite's previously drawn rectangle is
// erased with BG_COLOUR. The datapath then gets one update pulse. After that, every
// enabled sprite is redrawn with its current geometry. One pixel is emitted per clock.
// A clear_req pulse schedules a full-screen fill with BG_COLOUR instead of the next frame.
//
// Ports:
//   clk, resetn           clock and asynchronous active-low reset
//   run                   frames are started only while high
//   clear_req             one-cycle pulse, latched until the clear starts
//   obj_en/x/y/w/h/colour per-slot sprite description, sampled once per frame
//   x, y, colour, plot    registered pixel write to the VGA adapter
//   update                one-cycle pulse per frame for the game datapath
//   busy                  high whenever the sequencer is not idle
//   overrun               sticky flag; a tick arrived while busy
module frame_sequencer #(
  parameter int unsigned NUM_OBJ   = 4,
  parameter int unsigned FRAME_DIV = 833333,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 run,
  input  logic                 clear_req,
  input  logic [NUM_OBJ-1:0]   obj_en,
  input  logic [NUM_OBJ*8-1:0] obj_x,
  input  logic [NUM_OBJ*7-1:0] obj_y,
  input  logic [NUM_OBJ*4-1:0] obj_w,
  input  logic [NUM_OBJ*4-1:0] obj_h,
  input  logic [NUM_OBJ*3-1:0] obj_colour,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 plot,
  output logic                 update,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned SlotW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int unsigned CntW  = $clog2(FRAME_DIV);
  localparam logic [SlotW-1:0] LastSlot = SlotW'(NUM_OBJ - 1);
  localparam logic [CntW-1:0]  TickMax  = CntW'(FRAME_DIV - 1);
  localparam logic [7:0] ScrMaxX = 8'd159;
  localparam logic [6:0] ScrMaxY = 7'd119;

  typedef enum logic [2:0] {
    StIdle, StClear, StELoad, StEPlot, StUpd, StSettle, StDLoad, StDPlot
  } state_e;

  // ---------------------------------------------------------------------------
  // Frame tick: free-running, independent of run and of the sequencer state.
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] cnt_q;
  logic            tick;

  assign tick = (cnt_q == TickMax);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Unpacked view of the flattened sprite buses.
  // ---------------------------------------------------------------------------
  logic [7:0] in_x   [NUM_OBJ];
  logic [6:0] in_y   [NUM_OBJ];
  logic [3:0] in_w   [NUM_OBJ];
  logic [3:0] in_h   [NUM_OBJ];
  logic [2:0] in_col [NUM_OBJ];

  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      in_x[i]   = obj_x[8*i +: 8];
      in_y[i]   = obj_y[7*i +: 7];
      in_w[i]   = obj_w[4*i +: 4];
      in_h[i]   = obj_h[4*i +: 4];
      in_col[i] = obj_colour[3*i +: 3];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer state.
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [SlotW-1:0] slot_q;
  logic             clr_pend_q;

  // What is currently on screen, so the next frame can erase it.
  logic [NUM_OBJ-1:0] sh_en_q;
  logic [7:0]         sh_x_q [NUM_OBJ];
  logic [6:0]         sh_y_q [NUM_OBJ];
  logic [3:0]         sh_w_q [NUM_OBJ];
  logic [3:0]         sh_h_q [NUM_OBJ];

  // Rectangle being rastered.
  logic [7:0] cur_x_q;
  logic [6:0] cur_y_q;
  logic [3:0] cur_w_q;
  logic [3:0] cur_h_q;
  logic [2:0] cur_col_q;
  logic [3:0] dx_q;
  logic [3:0] dy_q;

  // Full-screen clear raster.
  logic [7:0] clr_x_q;
  logic [6:0] clr_y_q;

  // Sums are one bit wider than the screen coordinates so off-screen pixels can be
  // detected and suppressed; the truncated sum still goes out on x/y.
  logic [8:0] px;
  logic [7:0] py;
  logic       on_screen;
  logic       last_col;
  logic       last_row;
  logic       last_slot;

  always_comb begin
    px        = {1'b0, cur_x_q} + {5'b0, dx_q};
    py        = {1'b0, cur_y_q} + {4'b0, dy_q};
    on_screen = (px < 9'd160) && (py < 8'd120);
    last_col  = (dx_q == cur_w_q);
    last_row  = (dy_q == cur_h_q);
    last_slot = (slot_q == LastSlot);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      slot_q     <= '0;
      clr_pend_q <= 1'b0;
      sh_en_q    <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        sh_x_q[i] <= '0;
        sh_y_q[i] <= '0;
        sh_w_q[i] <= '0;
        sh_h_q[i] <= '0;
      end
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      cur_w_q    <= '0;
      cur_h_q    <= '0;
      cur_col_q  <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      clr_x_q    <= '0;
      clr_y_q    <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      update     <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      plot   <= 1'b0;
      update <= 1'b0;

      if (clear_req) begin
        clr_pend_q <= 1'b1;
      end
      // A tick outside IDLE is dropped; only the flag records it.
      if (tick && (state_q != StIdle)) begin
        overrun <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          // Same-cycle clear_req counts as pending and beats the tick.
          if (clr_pend_q || clear_req) begin
            state_q    <= StClear;
            clr_pend_q <= 1'b0;
            clr_x_q    <= '0;
            clr_y_q    <= '0;
            busy       <= 1'b1;
          end else if (tick && run) begin
            state_q <= StELoad;
            slot_q  <= '0;
            busy    <= 1'b1;
          end
        end

        StClear: begin
          x      <= clr_x_q;
          y      <= clr_y_q;
          colour <= BG_COLOUR;
          plot   <= 1'b1;
          if (clr_x_q == ScrMaxX) begin
            clr_x_q <= '0;
            if (clr_y_q == ScrMaxY) begin
              sh_en_q <= '0;
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              clr_y_q <= clr_y_q + 1'b1;
            end
          end else begin
            clr_x_q <= clr_x_q + 1'b1;
          end
        end

        StELoad: begin
          cur_x_q   <= sh_x_q[slot_q];
          cur_y_q   <= sh_y_q[slot_q];
          cur_w_q   <= sh_w_q[slot_q];
          cur_h_q   <= sh_h_q[slot_q];
          cur_col_q <= BG_COLOUR;
          dx_q      <= '0;
          dy_q      <= '0;
          if (sh_en_q[slot_q]) begin
            state_q <= StEPlot;
          end else if (last_slot) begin
            state_q <= StUpd;
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end

        StEPlot, StDPlot: begin
          x      <= px[7:0];
          y      <= py[6:0];
          colour <= cur_col_q;
          plot   <= on_screen;
          if (!last_col) begin
            dx_q <= dx_q + 1'b1;
          end else begin
            dx_q <= '0;
            if (!last_row) begin
              dy_q <= dy_q + 1'b1;
            end else begin
              dy_q <= '0;
              if (state_q == StEPlot) begin
                if (last_slot) begin
                  state_q <= StUpd;
                end else begin
                  slot_q  <= slot_q + 1'b1;
                  state_q <= StELoad;
                end
              end else begin
                if (last_slot) begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
                end else begin
                  slot_q  <= slot_q + 1'b1;
                  state_q <= StDLoad;
                end
              end
            end
          end
        end

        StUpd: begin
          update  <= 1'b1;
          state_q <= StSettle;
        end

        StSettle: begin
          slot_q  <= '0;
          state_q <= StDLoad;
        end

        StDLoad: begin
          sh_en_q[slot_q] <= obj_en[slot_q];
          sh_x_q[slot_q]  <= in_x[slot_q];
          sh_y_q[slot_q]  <= in_y[slot_q];
          sh_w_q[slot_q]  <= in_w[slot_q];
          sh_h_q[slot_q]  <= in_h[slot_q];
          cur_x_q         <= in_x[slot_q];
          cur_y_q         <= in_y[slot_q];
          cur_w_q         <= in_w[slot_q];
          cur_h_q         <= in_h[slot_q];
          cur_col_q       <= in_col[slot_q];
          dx_q            <= '0;
          dy_q            <= '0;
          if (obj_en[slot_q]) begin
            state_q <= StDPlot;
          end else if (last_slot) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end

        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: table of frames with hand-computed pixel
// streams, plus hand-written sequences for overrun, run drop, clear and reset.
module tb_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: FRAME_DIV=64, two slots ----------------
  logic        resetn_a = 1'b0;
  logic        run_a    = 1'b1;
  logic        clr_a    = 1'b0;
  logic [1:0]  en_a     = '0;
  logic [15:0] ox_a     = '0;
  logic [13:0] oy_a     = '0;
  logic [7:0]  ow_a     = '0;
  logic [7:0]  oh_a     = '0;
  logic [5:0]  oc_a     = '0;
  logic [7:0]  x_a;
  logic [6:0]  y_a;
  logic [2:0]  col_a;
  logic        plot_a, upd_a, busy_a, ovr_a;

  frame_sequencer #(.NUM_OBJ(2), .FRAME_DIV(64), .BG_COLOUR(3'b000)) dut_a (
    .clk(clk), .resetn(resetn_a), .run(run_a), .clear_req(clr_a),
    .obj_en(en_a), .obj_x(ox_a), .obj_y(oy_a), .obj_w(ow_a), .obj_h(oh_a),
    .obj_colour(oc_a), .x(x_a), .y(y_a), .colour(col_a), .plot(plot_a),
    .update(upd_a), .busy(busy_a), .overrun(ovr_a)
  );

  // ---------------- DUT B: FRAME_DIV=8, one 16x16 sprite ----------------
  logic        resetn_b = 1'b0;
  logic        run_b    = 1'b1;
  logic        clr_b    = 1'b0;
  logic [1:0]  en_b     = 2'b01;
  logic [15:0] ox_b     = '0;
  logic [13:0] oy_b     = '0;
  logic [7:0]  ow_b     = 8'h0f;
  logic [7:0]  oh_b     = 8'h0f;
  logic [5:0]  oc_b     = 6'd5;
  logic [7:0]  x_b;
  logic [6:0]  y_b;
  logic [2:0]  col_b;
  logic        plot_b, upd_b, busy_b, ovr_b;

  frame_sequencer #(.NUM_OBJ(2), .FRAME_DIV(8), .BG_COLOUR(3'b000)) dut_b (
    .clk(clk), .resetn(resetn_b), .run(run_b), .clear_req(clr_b),
    .obj_en(en_b), .obj_x(ox_b), .obj_y(oy_b), .obj_w(ow_b), .obj_h(oh_b),
    .obj_colour(oc_b), .x(x_b), .y(y_b), .colour(col_b), .plot(plot_b),
    .update(upd_b), .busy(busy_b), .overrun(ovr_b)
  );

  // ---------------- Monitors (sample on the falling edge) ----------------
  logic [17:0] pq[$];
  int upd_cnt = 0, busy_cnt = 0, upd_cnt_b = 0, busy_cnt_b = 0;

  always @(negedge clk) begin
    if (resetn_a) begin
      if (plot_a) pq.push_back({x_a, y_a, col_a});
      if (upd_a) upd_cnt++;
      if (busy_a) busy_cnt++;
    end
    if (resetn_b) begin
      if (upd_b) upd_cnt_b++;
      if (busy_b) busy_cnt_b++;
    end
  end

  // ---------------- Checking ----------------
  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic logic [17:0] pix_of(input int px, input int py, input int pc);
    return {8'(px), 7'(py), 3'(pc)};
  endfunction

  typedef struct {
    logic [1:0]        en;
    logic [15:0]       ox;
    logic [13:0]       oy;
    logic [7:0]        ow;
    logic [7:0]        oh;
    logic [5:0]        oc;
    int                busy_len;
    int                n_pix;
    logic [11:0][17:0] pix;
  } frame_vec_t;

  frame_vec_t vec[5];

  function automatic frame_vec_t mk(input logic [1:0] en,
      input int x0, input int y0, input int w0, input int h0, input int c0,
      input int x1, input int y1, input int w1, input int h1, input int c1,
      input int bl);
    frame_vec_t v;
    v.en = en;
    v.ox = {8'(x1), 8'(x0)};
    v.oy = {7'(y1), 7'(y0)};
    v.ow = {4'(w1), 4'(w0)};
    v.oh = {4'(h1), 4'(h0)};
    v.oc = {3'(c1), 3'(c0)};
    v.busy_len = bl;
    v.n_pix = 0;
    v.pix = '0;
    return v;
  endfunction

  task automatic add_pix(input int i, input int px, input int py, input int pc);
    vec[i].pix[vec[i].n_pix] = pix_of(px, py, pc);
    vec[i].n_pix++;
  endtask

  task automatic apply(input int i);
    en_a = vec[i].en; ox_a = vec[i].ox; oy_a = vec[i].oy;
    ow_a = vec[i].ow; oh_a = vec[i].oh; oc_a = vec[i].oc;
  endtask

  // Waits for one frame of DUT A (must be called while idle).
  task automatic run_frame(input bit drop_run, output int lat, output int pbase,
                           output int blen, output int nupd);
    int bb, ub;
    bit seen;
    pbase = pq.size(); bb = busy_cnt; ub = upd_cnt; lat = 0; seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (busy_a) seen = 1'b1;
    end
    if (!seen) begin
      check("frame_start_timeout", 32'(seen), 1);
      blen = 0; nupd = 0;
      return;
    end
    if (drop_run) run_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30000 && !seen; i++) begin
      @(negedge clk);
      if (!busy_a) seen = 1'b1;
    end
    if (!seen) check("frame_end_timeout", 32'(seen), 1);
    repeat (2) @(negedge clk);
    blen = busy_cnt - bb;
    nupd = upd_cnt - ub;
  endtask

  task automatic wait_high_a(input int which, input int bound, input string name);
    bit seen;
    logic sig;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      sig = (which == 0) ? busy_a : (which == 1) ? upd_a : plot_a;
      if (sig) seen = 1'b1;
    end
    if (!seen) check(name, 32'(seen), 1);
  endtask

  int lat, pbase, blen, nupd, bb, ub, bad;
  logic [17:0] got, want;
  bit seen;

  initial begin
    // Frame table: slot 0 / slot 1 setup, expected busy length and pixel stream.
    vec[0] = mk(2'b01, 10, 20, 1, 1, 4,   0, 0, 0, 0, 0, 10);
    add_pix(0, 10, 20, 4); add_pix(0, 11, 20, 4); add_pix(0, 10, 21, 4); add_pix(0, 11, 21, 4);
    vec[1] = mk(2'b01, 12, 20, 1, 1, 4,   0, 0, 0, 0, 0, 14);
    add_pix(1, 10, 20, 0); add_pix(1, 11, 20, 0); add_pix(1, 10, 21, 0); add_pix(1, 11, 21, 0);
    add_pix(1, 12, 20, 4); add_pix(1, 13, 20, 4); add_pix(1, 12, 21, 4); add_pix(1, 13, 21, 4);
    vec[2] = mk(2'b01, 158, 118, 3, 3, 2, 0, 0, 0, 0, 0, 26);
    add_pix(2, 12, 20, 0); add_pix(2, 13, 20, 0); add_pix(2, 12, 21, 0); add_pix(2, 13, 21, 0);
    add_pix(2, 158, 118, 2); add_pix(2, 159, 118, 2); add_pix(2, 158, 119, 2);
    add_pix(2, 159, 119, 2);
    vec[3] = mk(2'b10, 158, 118, 3, 3, 2, 0, 0, 0, 2, 7, 25);
    add_pix(3, 158, 118, 0); add_pix(3, 159, 118, 0); add_pix(3, 158, 119, 0);
    add_pix(3, 159, 119, 0);
    add_pix(3, 0, 0, 7); add_pix(3, 0, 1, 7); add_pix(3, 0, 2, 7);
    vec[4] = mk(2'b11, 100, 50, 2, 0, 1, 0, 0, 0, 2, 7, 15);
    add_pix(4, 0, 0, 0); add_pix(4, 0, 1, 0); add_pix(4, 0, 2, 0);
    add_pix(4, 100, 50, 1); add_pix(4, 101, 50, 1); add_pix(4, 102, 50, 1);
    add_pix(4, 0, 0, 7); add_pix(4, 0, 1, 7); add_pix(4, 0, 2, 7);

    // ---- Reset values ----
    repeat (3) @(negedge clk);
    check("rst_x", 32'(x_a), 0);
    check("rst_y", 32'(y_a), 0);
    check("rst_colour", 32'(col_a), 0);
    check("rst_plot", 32'(plot_a), 0);
    check("rst_update", 32'(upd_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_overrun", 32'(ovr_a), 0);

    // ---- Overrun on DUT B: 262-cycle frame, tick every 8 ----
    @(negedge clk);
    resetn_b = 1'b1;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (busy_b) seen = 1'b1;
    end
    check("b_first_tick_latency", 32'(lat), 8);
    check("b_overrun_at_start", 32'(ovr_b), 0);
    repeat (7) @(negedge clk);
    check("b_overrun_before_tick", 32'(ovr_b), 0);
    @(negedge clk);
    check("b_overrun_at_tick", 32'(ovr_b), 1);
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (!busy_b) seen = 1'b1;
    end
    run_b = 1'b0;
    check("b_frame_end_seen", 32'(seen), 1);
    check("b_busy_len", 32'(busy_cnt_b), 262);
    check("b_update_count", 32'(upd_cnt_b), 1);
    repeat (20) @(negedge clk);
    check("b_overrun_sticky", 32'(ovr_b), 1);

    // ---- Frame table on DUT A ----
    for (int i = 0; i < 5; i++) begin
      apply(i);
      if (i == 0) begin
        @(negedge clk);
        resetn_a = 1'b1;
      end
      run_frame(1'b0, lat, pbase, blen, nupd);
      if (i == 0) check("first_tick_latency", 32'(lat), 64);
      check($sformatf("f%0d_busy_len", i), 32'(blen), 32'(vec[i].busy_len));
      check($sformatf("f%0d_update_count", i), 32'(nupd), 1);
      check($sformatf("f%0d_plot_count", i), 32'(pq.size() - pbase), 32'(vec[i].n_pix));
      for (int k = 0; k < vec[i].n_pix; k++) begin
        got = (pbase + k < pq.size()) ? pq[pbase + k] : '1;
        want = vec[i].pix[k];
        check($sformatf("f%0d_pix%0d", i, k), 32'(got), 32'(want));
      end
      check($sformatf("f%0d_busy_after", i), 32'(busy_a), 0);
    end
    check("overrun_after_table", 32'(ovr_a), 0);

    // ---- run low: ticks ignored, no overrun ----
    run_a = 1'b0;
    bb = busy_cnt;
    repeat (150) @(negedge clk);
    check("run_low_no_frame", 32'(busy_cnt - bb), 0);
    check("run_low_no_overrun", 32'(ovr_a), 0);

    // ---- run dropped mid-frame: frame completes (erase 6 + draw 6), no new one ----
    run_a = 1'b1;
    run_frame(1'b1, lat, pbase, blen, nupd);
    check("drop_busy_len", 32'(blen), 18);
    check("drop_plot_count", 32'(pq.size() - pbase), 12);
    bb = busy_cnt;
    repeat (150) @(negedge clk);
    check("drop_no_new_frame", 32'(busy_cnt - bb), 0);

    // ---- clear_req coincident with a tick in IDLE ----
    run_a = 1'b1;
    wait_high_a(0, 100, "clr_align_timeout");
    repeat (63) @(negedge clk);
    pbase = pq.size(); ub = upd_cnt; bb = busy_cnt;
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("clear_busy_rise", 32'(busy_a), 1);
    seen = 1'b0;
    for (int i = 0; i < 25000 && !seen; i++) begin
      @(negedge clk);
      if (!busy_a) seen = 1'b1;
    end
    check("clear_end_seen", 32'(seen), 1);
    repeat (2) @(negedge clk);
    check("clear_busy_len", 32'(busy_cnt - bb), 19200);
    check("clear_plot_count", 32'(pq.size() - pbase), 19200);
    check("clear_tick_not_served", 32'(upd_cnt - ub), 0);
    bad = 0;
    for (int k = 0; k < 19200 && pbase + k < pq.size(); k++) begin
      if (pq[pbase + k] !== pix_of(k % 160, k / 160, 0)) bad++;
    end
    check("clear_raster_errors", 32'(bad), 0);
    check("clear_overrun", 32'(ovr_a), 1);
    run_frame(1'b0, lat, pbase, blen, nupd);
    check("post_clear_busy_len", 32'(blen), 12);
    check("post_clear_plot_count", 32'(pq.size() - pbase), 6);
    got = (pbase < pq.size()) ? pq[pbase] : '1;
    check("post_clear_first_pix", 32'(got), 32'(pix_of(100, 50, 1)));

    // ---- Reset during D_PLOT ----
    wait_high_a(0, 100, "rstplot_busy_timeout");
    wait_high_a(1, 100, "rstplot_update_timeout");
    wait_high_a(2, 100, "rstplot_plot_timeout");
    #2;
    resetn_a = 1'b0;
    #1;
    check("rstplot_plot", 32'(plot_a), 0);
    check("rstplot_busy", 32'(busy_a), 0);
    check("rstplot_overrun", 32'(ovr_a), 0);
    @(negedge clk);
    resetn_a = 1'b1;
    run_frame(1'b0, lat, pbase, blen, nupd);
    check("rstplot_latency", 32'(lat), 64);
    check("rstplot_busy_len", 32'(blen), 12);
    check("rstplot_plot_count", 32'(pq.size() - pbase), 6);
    got = (pbase < pq.size()) ? pq[pbase] : '1;
    check("rstplot_first_pix", 32'(got), 32'(pix_of(100, 50, 1)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Parametrised frame sequencer for the 160x120 game display. On every frame tick it erases each sprite's previous rectangle, pulses the datapath to advance game state, then redraws every enabled sprite, emitting one pixel per clock to the vga_adapter (x, y, colour, plot). It replaces the hand-coded erase/move/draw sequencing and the fixed-constant rate divider with one block that handles NUM_OBJ sprites of variable size, plus full-screen clear and overrun detection.

## Interface

Parameters:
- NUM_OBJ, 4: sprite slots; 1..8.
- FRAME_DIV, 833333: clk cycles per frame tick, giving 60 Hz at 50 MHz; minimum 2.
- BG_COLOUR, 3'b000: erase and clear colour.

Ports:
- clk  in  1  system clock, all logic on posedge.
- resetn  in  1  asynchronous active-low reset.
- run  in  1  level; frames are sequenced only while high.
- clear_req  in  1  one-cycle pulse; requests a full-screen fill with BG_COLOUR.
- obj_en  in  NUM_OBJ  per-slot enable.
- obj_x  in  NUM_OBJ*8  top-left x; slot i is at [8i+7:8i].
- obj_y  in  NUM_OBJ*7  top-left y.
- obj_w  in  NUM_OBJ*4  width minus 1 (1..16 px).
- obj_h  in  NUM_OBJ*4  height minus 1.
- obj_colour  in  NUM_OBJ*3  sprite colour.
- x  out  8  pixel x to the VGA adapter.
- y  out  7  pixel y.
- colour  out  3  pixel colour.
- plot  out  1  write strobe; x, y and colour are valid when high.
- update  out  1  one-cycle pulse; the datapath advances positions on it.
- busy  out  1  high in any state except IDLE.
- overrun  out  1  sticky; set when a tick lands while busy.

## Operation

- Tick counter: counts 0..FRAME_DIV-1 and wraps. tick=1 for the cycle in which the count is FRAME_DIV-1. It runs regardless of run or state.
- Shadow registers per slot: sh_en, sh_x, sh_y, sh_w, sh_h. They hold what is currently drawn on screen.
- States: IDLE, CLEAR, E_LOAD, E_PLOT, UPD, SETTLE, D_LOAD, D_PLOT.
- IDLE:
  - If clear_req is pending, go to CLEAR. clear_req is latched in any state and cleared on entering CLEAR.
  - Else if tick && run, go to E_LOAD with slot=0.
  - The CLEAR check has priority over the tick check.
- CLEAR:
  - Raster y 0..119 (outer), x 0..159 (inner), plot=1, colour=BG_COLOUR: 19200 cycles.
  - Clears all sh_en, then returns to IDLE.
- E_LOAD (1 cycle):
  - Loads slot geometry from the shadow registers and sets dx=dy=0.
  - If sh_en[slot], go to E_PLOT.
  - Else advance to the next slot, or to UPD after the last slot.
- E_PLOT:
  - One pixel per cycle; raster dx 0..w inner, dy 0..h outer; colour=BG_COLOUR.
  - After the last pixel, advance slot: E_LOAD, or UPD.
- UPD (1 cycle): update=1.
- SETTLE (1 cycle): the datapath drives new obj_* values.
- D_LOAD (1 cycle):
  - Samples obj_* for the slot into the shadow registers (sh_en <= obj_en[slot]).
  - Goes to D_PLOT if enabled; else advances to the next slot, or to IDLE after the last slot.
- D_PLOT: same raster as E_PLOT, using obj_colour[slot].
- Clipping:
  - px = obj_x + dx is computed 9-bit; py = obj_y + dy is computed 8-bit.
  - If px ≥ 160 or py ≥ 120, plot=0 for that cycle but the cycle is still consumed.
  - x and y output the truncated sums.
- run falling mid-frame: the current frame completes; no new frame starts.
- Tick while not IDLE: the tick is dropped and overrun <= 1. Only reset clears overrun.
- Tick in IDLE with run=0: ignored; overrun is not set.

## Timing

- Reset values: x=0, y=0, colour=0, plot=0, update=0, busy=0, overrun=0; all sh_en=0; tick count=0; state=IDLE; clear pending=0.
- Reset mid-frame aborts immediately to the reset values; no partial pixels follow.
- First tick: the FRAME_DIV-th clk edge after resetn rises.
- Tick to first E_LOAD: 1 cycle. plot is a registered output, valid the cycle after its state is entered.
- Frame length in cycles:
  - NUM_OBJ (E_LOAD)
  - + Σ enabled-shadow (w+1)(h+1)
  - + 2 (UPD, SETTLE)
  - + NUM_OBJ (D_LOAD)
  - + Σ enabled (w+1)(h+1)
- busy rises the cycle after tick and falls on return to IDLE.
- update is exactly one cycle wide, once per frame.
- obj_* is sampled only in D_LOAD, so it may change at any other time.

## Test plan

- Reset and first frame:
  - Setup: FRAME_DIV=64, NUM_OBJ=2, slot 0 enabled at (10,20) with w=h=1 and colour 3'b100; slot 1 disabled; run=1.
  - Required: no erase plots (shadow empty); one update pulse; 4 plots with colour 100 at (10,20), (11,20), (10,21), (11,21); busy low afterwards.
- Move and erase:
  - Setup: on update, the datapath moves slot 0 to (12,20).
  - Required: the next frame erases (10..11, 20..21) with colour 000, then draws (12..13, 20..21) with colour 100.
- Clip:
  - Setup: slot at (158,118), w=h=3.
  - Required: 16 pixel cycles; plot=1 only for (158,118), (159,118), (158,119), (159,119).
- Overrun:
  - Setup: FRAME_DIV=8, one 16x16 sprite.
  - Required: overrun goes high at the first tick during the frame and stays high; no second frame starts mid-frame.
- Clear priority:
  - Setup: clear_req pulsed in the same cycle as a tick in IDLE.
  - Required: 19200 plots of BG_COLOUR, sh_en all 0; the tick is not served.
- Reset mid-plot:
  - Setup: assert resetn=0 during D_PLOT.
  - Required: plot=0 and busy=0 immediately (asynchronously); after release, the first frame performs no erase.
